// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART receive path.
//   UART_DATA_W        - receiver byte width
//   UART_RX_FIFO_DEPTH - default receive FIFO depth
//   lvl_op_e           - FIFO occupancy update selector
//   clog2()            - ceiling log2, used to size FIFO pointers
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_INC,
        LVL_DEC
    } lvl_op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver/bus-side signal bundle of the receive FIFO.
//   rx_data, rx_valid   - byte and data-received flag/strobe from the receiver
//   rd_en, ovr_clr      - bus pop request and overrun clear
//   rd_data             - head entry (0 when empty)
//   level, empty, full  - occupancy status
//   overrun, irq        - sticky drop flag and threshold interrupt
// master: drives receiver/bus requests; slave: the FIFO itself.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned ADDR_W = clog2(UART_RX_FIFO_DEPTH)
);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rd_en;
    logic              ovr_clr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;
    logic              overrun;
    logic              irq;

    modport master (
        output rx_data, rx_valid, rd_en, ovr_clr,
        input  rd_data, level, empty, full, overrun, irq
    );

    modport slave (
        input  rx_data, rx_valid, rd_en, ovr_clr,
        output rd_data, level, empty, full, overrun, irq
    );

endinterface

// File: rtl/uart_rx_push_gen.sv
// uart_rx_push_gen: derives the FIFO push request from the receiver valid.
//   clk, rst  - clock, asynchronous active-high reset
//   rx_valid  - receiver data-received flag (EDGE_DETECT=1) or strobe (0)
//   push      - one-cycle write request into the FIFO
module uart_rx_push_gen
#(
    parameter int unsigned EDGE_DETECT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_valid,
    output logic push
);

    logic rx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_valid_q <= 1'b0;
        else     rx_valid_q <= rx_valid;
    end

    generate
        if (EDGE_DETECT != 0) begin : g_edge
            // A level-style flag may stay high for several cycles; only its
            // rising edge represents a new byte.
            assign push = rx_valid & ~rx_valid_q;
        end else begin : g_strobe
            assign push = rx_valid;
        end
    endgenerate

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular buffer between the UART receiver and bus reads.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - uart_rx_fifo_if slave: receiver input, pop/clear requests,
//              first-word-fall-through head byte and status flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W      = UART_DATA_W,
    parameter int unsigned DEPTH       = UART_RX_FIFO_DEPTH,
    parameter int unsigned ADDR_W      = clog2(DEPTH),
    parameter int unsigned IRQ_THRESH  = 8,
    parameter int unsigned EDGE_DETECT = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus
);

    logic                push;
    logic                pop;
    logic                wr_ok;
    logic                drop;
    logic                empty_w;
    logic                full_w;
    logic [ADDR_W:0]     wr_ptr;
    logic [ADDR_W:0]     rd_ptr;
    logic [ADDR_W:0]     level_q;
    logic                overrun_q;
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]   rd_idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    lvl_op_e             lvl_op;

    uart_rx_push_gen #(
        .EDGE_DETECT (EDGE_DETECT)
    ) u_push_gen (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (bus.rx_valid),
        .push     (push)
    );

    assign wr_idx  = wr_ptr[ADDR_W-1:0];
    assign rd_idx  = rd_ptr[ADDR_W-1:0];

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_idx == rd_idx) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign pop     = bus.rd_en & ~empty_w;
    // A simultaneous pop frees the slot the push needs, even when full.
    assign wr_ok   = push & (~full_w | pop);
    assign drop    = push & full_w & ~pop;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (wr_ok && !pop)      lvl_op = LVL_INC;
        else if (pop && !wr_ok) lvl_op = LVL_DEC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (ADDR_W+1)'(1);

            case (lvl_op)
                LVL_INC: level_q <= level_q + (ADDR_W+1)'(1);
                LVL_DEC: level_q <= level_q - (ADDR_W+1)'(1);
                default: level_q <= level_q;
            endcase

            // A drop in the same cycle as a clear wins so no loss goes unseen.
            if (drop)             overrun_q <= 1'b1;
            else if (bus.ovr_clr) overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= bus.rx_data;
    end

    assign bus.rd_data = empty_w ? '0 : mem[rd_idx];
    assign bus.level   = level_q;
    assign bus.empty   = empty_w;
    assign bus.full    = full_w;
    assign bus.overrun = overrun_q;
    assign bus.irq     = (level_q >= (ADDR_W+1)'(IRQ_THRESH));

endmodule
